pds_rx_buffer: RTL and testbench

PDS_RX_BUFFER -- requirements
Module: pds_rx_buffer

---
 rtl/pds_rx_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_pds_rx_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pds_rx_buffer.sv
// Receive buffer for port-driver packets: bytes are stored speculatively and committed
// only after a matching parity byte, then streamed out with start/end-of-packet flags.
module pds_rx_buffer #(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        suspend,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t       DEPTH_P   = ptr_t'(DEPTH);
    localparam ptr_t       MIN_FREE  = ptr_t'(MAX_LEN + 3);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        PARITY,
        DISCARD
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LEN,
        TX_PAYLOAD,
        TX_PARITY
    } tx_state_t;

    logic [7:0] mem [DEPTH];

    ptr_t       wr_ptr;
    ptr_t       commit_ptr;
    ptr_t       rd_ptr;
    rx_state_t  rx_state;
    tx_state_t  tx_state;
    logic [7:0] rx_rem;
    logic [7:0] rx_parity;
    logic [7:0] tx_rem;

    ptr_t       spec_occupancy;
    logic       spec_full;
    logic       mem_we;
    logic [7:0] rd_word;
    logic       load_out;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign spec_occupancy = wr_ptr - rd_ptr;
    assign spec_full      = (spec_occupancy == DEPTH_P);
    assign suspend        = (DEPTH_P - spec_occupancy) < MIN_FREE;
    assign mem_we         = in_valid && (rx_state != DISCARD) && !spec_full;
    assign rd_word        = mem[rd_ptr[AW-1:0]];
    assign load_out       = (!out_valid || out_ready) && (rd_ptr != commit_ptr);

    // Every accepted byte lands in the speculative region; only pointers decide whether it survives.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Receive FSM: parses the packet, tracks parity and commits or rewinds the write pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state   <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rx_rem     <= '0;
            rx_parity  <= '0;
            good_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (in_valid) begin
                        if (spec_full) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            rx_state <= DISCARD;
                        end else begin
                            wr_ptr    <= wr_ptr + ptr_t'(1);
                            rx_parity <= in_data;
                            rx_state  <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (!in_valid) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= IDLE;
                    end else if (spec_full || in_data == 8'd0 || in_data > MAX_LEN_B) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= DISCARD;
                    end else begin
                        wr_ptr    <= wr_ptr + ptr_t'(1);
                        rx_parity <= rx_parity ^ in_data;
                        rx_rem    <= in_data;
                        rx_state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!in_valid) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= IDLE;
                    end else if (spec_full) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= DISCARD;
                    end else begin
                        wr_ptr    <= wr_ptr + ptr_t'(1);
                        rx_parity <= rx_parity ^ in_data;
                        rx_rem    <= rx_rem - 8'd1;
                        if (rx_rem == 8'd1) begin
                            rx_state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (!in_valid) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= IDLE;
                    end else if (spec_full) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= DISCARD;
                    end else if (in_data == rx_parity) begin
                        wr_ptr     <= wr_ptr + ptr_t'(1);
                        commit_ptr <= wr_ptr + ptr_t'(1);
                        good_cnt   <= sat_inc(good_cnt);
                        rx_state   <= IDLE;
                    end else begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        rx_state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (!in_valid) begin
                        rx_state <= IDLE;
                    end
                end
                default: begin
                    rx_state <= IDLE;
                end
            endcase
        end
    end

    // Output FSM: walks committed bytes, re-parsing the length to place the sop/eop flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            rd_ptr    <= '0;
            tx_rem    <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= rd_word;
            out_sop   <= (tx_state == TX_IDLE);
            out_eop   <= (tx_state == TX_PARITY);
            rd_ptr    <= rd_ptr + ptr_t'(1);
            case (tx_state)
                TX_IDLE: begin
                    tx_state <= TX_LEN;
                end
                TX_LEN: begin
                    tx_rem   <= rd_word;
                    tx_state <= TX_PAYLOAD;
                end
                TX_PAYLOAD: begin
                    tx_rem <= tx_rem - 8'd1;
                    if (tx_rem == 8'd1) begin
                        tx_state <= TX_PARITY;
                    end
                end
                TX_PARITY: begin
                    tx_state <= TX_IDLE;
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pds_rx_buffer.sv
// Directed bench for pds_rx_buffer: a packet table plus hand-written latency,
// backpressure/overflow/wrap and mid-packet reset sequences.
module tb_pds_rx_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        suspend;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    pds_rx_buffer #(.DEPTH(64), .MAX_LEN(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .suspend  (suspend),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .good_cnt (good_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [19:0][7:0] b;
        int               n;
        bit               good;
        int               exp_good;
        int               exp_drop;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[9];
    int    checks   = 0;
    int    errors   = 0;
    int    rx_count = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [159:0] b, input int n, input bit good,
                                 input int eg, input int ed);
        vec_t v;
        v.b        = b;
        v.n        = n;
        v.good     = good;
        v.exp_good = eg;
        v.exp_drop = ed;
        return v;
    endfunction

    // 16-byte payload base..base+15; parity is supplied by the caller
    function automatic vec_t make_big(input logic [7:0] h, input logic [7:0] base,
                                      input logic [7:0] par, input bit good);
        vec_t v;
        v.b     = '0;
        v.b[19] = h;
        v.b[18] = 8'h10;
        for (int i = 0; i < 16; i++) v.b[17-i] = base + 8'(i);
        v.b[1]     = par;
        v.n        = 19;
        v.good     = good;
        v.exp_good = 0;
        v.exp_drop = 0;
        return v;
    endfunction

    // Caller is positioned just after a rising edge; first byte is sampled on the next edge.
    task automatic apply_stimulus(input vec_t v);
        if (v.good) begin
            for (int i = 0; i < v.n; i++) begin
                beat_t e;
                e.d   = v.b[19-i];
                e.sop = (i == 0);
                e.eop = (i == v.n - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_data  = v.b[19-i];
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            @(posedge clock);
            #1;
        end
        check_output(name, exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            rx_count++;
            if (exp_q.size() == 0) begin
                check_output("unexpected_beat", {out_data, out_sop, out_eop}, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_output("out_beat", {out_data, out_sop, out_eop}, {e.d, e.sop, e.eop});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t big [4];
        vec_t wrap_vec;

        vecs[0] = mkv({8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01, 112'h0}, 6, 1'b1, 1, 0);
        vecs[1] = mkv({8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'hFF, 112'h0}, 6, 1'b0, 1, 1);
        vecs[2] = mkv({8'h01, 8'h02, 8'hAA, 8'h55, 8'hFC, 120'h0}, 5, 1'b1, 2, 1);
        vecs[3] = mkv({8'h03, 8'h04, 8'h10, 8'h20, 128'h0}, 4, 1'b0, 2, 2);
        vecs[4] = mkv({8'h00, 8'h00, 8'h5A, 136'h0}, 3, 1'b0, 2, 3);
        vecs[5] = mkv({8'h01, 8'h11, 8'hAA, 8'hBB, 8'hCC, 120'h0}, 5, 1'b0, 2, 4);
        vecs[6] = mkv({8'h03, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                       8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h13, 8'h00},
                      19, 1'b1, 3, 4);
        vecs[7] = mkv({8'h00, 8'h01, 8'h7E, 8'h7F, 128'h0}, 4, 1'b1, 4, 4);
        vecs[8] = mkv({8'h02, 8'h02, 8'h01, 8'h02, 128'h0}, 4, 1'b0, 4, 5);

        big[0] = make_big(8'h03, 8'h00, 8'h13, 1'b1);
        big[1] = make_big(8'h01, 8'h20, 8'h11, 1'b1);
        big[2] = make_big(8'h02, 8'h40, 8'h12, 1'b1);
        big[3] = make_big(8'h00, 8'h60, 8'h10, 1'b0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_out_flags", {out_sop, out_eop}, 0);
        check_output("reset_out_data", out_data, 0);
        check_output("reset_suspend", suspend, 0);
        check_output("reset_good_cnt", good_cnt, 0);
        check_output("reset_drop_cnt", drop_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i]);
            wait_drain("table_drain");
            check_output("table_good_cnt", good_cnt, vecs[i].exp_good);
            check_output("table_drop_cnt", drop_cnt, vecs[i].exp_drop);
        end

        // commit on the parity edge, first output byte one edge later
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat_t e;
            e.d   = vecs[0].b[19-i];
            e.sop = (i == 0);
            e.eop = (i == 5);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[0].b[19-i];
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check_output("lat_commit_good", good_cnt, 1);
        check_output("lat_valid_k", out_valid, 0);
        @(posedge clock);
        #1;
        check_output("lat_valid_k1", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h02});
        wait_drain("lat_drain");

        // backpressure, overflow and pointer wrap
        reset = 1'b1;
        #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(big[0]);
        check_output("bp_suspend_1", suspend, 0);
        check_output("bp_hold_head", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h03});
        apply_stimulus(big[1]);
        apply_stimulus(big[2]);
        check_output("bp_suspend_3", suspend, 1);
        apply_stimulus(big[3]);
        check_output("ovf_drop_cnt", drop_cnt, 1);
        check_output("ovf_good_cnt", good_cnt, 3);
        check_output("bp_hold_stable", {out_valid, out_data}, {1'b1, 8'h03});
        rx_count  = 0;
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check_output("bp_byte_count", rx_count, 57);
        check_output("bp_suspend_drained", suspend, 0);
        apply_stimulus(big[0]);
        wait_drain("wrap_drain_big");
        wrap_vec = vecs[2];
        apply_stimulus(wrap_vec);
        wait_drain("wrap_drain_small");
        check_output("wrap_good_cnt", good_cnt, 5);

        // reset mid-payload with one packet already committed
        out_ready = 1'b0;
        apply_stimulus(vecs[0]);
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(posedge clock);
        #1;
        in_data = 8'h02;
        @(posedge clock);
        #1;
        in_data = 8'hAA;
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_q.delete();
        #1;
        check_output("mid_reset_out_valid", out_valid, 0);
        check_output("mid_reset_counts", {good_cnt, drop_cnt}, 0);
        check_output("mid_reset_suspend", suspend, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        apply_stimulus(vecs[2]);
        wait_drain("post_reset_drain");
        check_output("post_reset_good", good_cnt, 1);
        check_output("post_reset_drop", drop_cnt, 0);
        @(posedge clock);
        #1;
        check_output("post_reset_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
